uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
Receive half of the on-chip UART that feeds the core's memory-mapped I/O path. It samples the FPGA_SERIAL_RX line and deserialises 8N1 frames, LSB first. Each byte is presented on a valid/ready interface that the load path reads from the UART data register.
The block is single-clock, with no FIFO. Only one received byte is held at a time.

Parameters:
CLOCK_FREQ, 50_000_000, core clock frequency in Hz.
BAUD_RATE, 115200, serial bit rate.
Derived, not overridable:
- SYMBOL_EDGE_TIME = CLOCK_FREQ/BAUD_RATE, the number of clocks per bit.
- SAMPLE_TIME = SYMBOL_EDGE_TIME/2.
- CW = $clog2(SYMBOL_EDGE_TIME), the counter width.

Ports:
clk  input  1  core clock
rst  input  1  asynchronous, active-low reset
serial_in  input  1  raw RX line; idles high; asynchronous to clk
data_out  output  8  received byte
data_out_valid  output  1  data_out holds an unconsumed byte
data_out_ready  input  1  consumer accepts the byte
framing_err  output  1  one-cycle pulse when the stop bit is sampled low
overrun  output  1  one-cycle pulse when a byte is dropped because the holding register is full
parity_err  output  1  one-cycle pulse on parity mismatch; tied 0 unless UART_RX_PARITY_EN is defined

Behaviour:
- Reset (rst asserted low, asynchronous) clears the following:
  - state = IDLE.
  - Both synchroniser flops = 1.
  - Bit counter = 0, clock counter = 0, shift register = 0.
  - data_out = 8'h00, data_out_valid = 0, framing_err = 0, overrun = 0, parity_err = 0.
- Reset mid-frame abandons the frame with no error pulse, and clears any held byte.
- serial_in passes through a 2-flop synchroniser; rx_s is its output. Every reference to "the line" below means rx_s.
- FSM states: IDLE, START, DATA, [PARITY], STOP, WAIT_HIGH.
  - IDLE: when rx_s == 0, go to START with clock counter = 0.
  - START: count to SAMPLE_TIME-1, then sample the line.
    - Line = 1: glitch; return to IDLE with no pulse.
    - Line = 0: go to DATA with clock counter = 0 and bit counter = 0.
  - DATA: when the clock counter reaches SYMBOL_EDGE_TIME-1, shift the sampled bit into the MSB of the shift register (shifting right), increment the bit counter, and reset the clock counter. After the 8th bit, go to STOP (or PARITY if the macro is defined).
  - STOP: at SYMBOL_EDGE_TIME-1, sample the line.
    - Line = 1: deliver the byte (see handshake rules), then go to IDLE.
    - Line = 0: pulse framing_err, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s == 1, then go to IDLE. This prevents a break condition from being re-read as a start bit.
- Timing: the stop sample occurs at SAMPLE_TIME + 9*SYMBOL_EDGE_TIME clocks after IDLE detects rx_s low. data_out_valid rises on the next clock edge. All error pulses are registered and last exactly one cycle.
- Handshake:
  - When data_out_valid = 1, data_out is stable until a cycle with valid & ready. data_out_valid falls on the edge after that cycle.
  - A delivery when valid = 0: load data_out and set valid.
  - A delivery when valid = 1 and ready = 0: the new byte is dropped. Pulse overrun; the old byte and valid stay unchanged.
  - A delivery in the same cycle as valid & ready: the new byte is loaded, valid stays 1, and there is no overrun.
  - data_out_ready while valid = 0 is ignored.
- Counter arithmetic is unsigned and CW bits wide. The counter never wraps, because it is reset at each terminal count.

Optional Feature:
UART_RX_PARITY_EN:
- Defined: frames are 8E1. The PARITY state samples the parity bit at SYMBOL_EDGE_TIME-1.
  - If XOR(data bits, parity bit) != 0: pulse parity_err, still check the stop bit, never deliver the byte, and no overrun is raised for it.
  - Otherwise go to STOP normally.
  - Delivery occurs one bit period later than in 8N1.
- Undefined: the PARITY state does not exist, and parity_err is constant 0.

Test Plan:
All scenarios use CLOCK_FREQ=1000 and BAUD_RATE=100, giving SYMBOL_EDGE_TIME=10 and SAMPLE_TIME=5.
1. Send 8'hA5 (8N1) with ready=0 -> data_out=8'hA5 and valid rises 98±1 clocks after the serial_in falling edge. Assert ready for 1 cycle -> valid=0 on the next edge.
2. Send 8'h3C, then 8'hC3 back-to-back with ready held 0 -> data_out stays 3C, overrun pulses once at the end of the second frame, and valid remains 1.
3. Hold ready=1 continuously and send 8'h01, 8'hFF, 8'h80 -> three valid/ready transfers with those values, and overrun never asserts.
4. Drive serial_in low for 3 clocks, then high -> no valid and no error; the FSM is back in IDLE, and a following 8'h55 frame is received correctly.
5. Send 8'h12 with the stop bit driven 0 and the line held low for 30 more clocks -> framing_err pulses once, no valid, and no spurious frame. The next 8'h34 is received correctly.
6. Assert rst in the middle of bit 4 of a frame -> all outputs are 0 immediately. After release, 8'h7E is received correctly. With UART_RX_PARITY_EN, 8'h7E with a wrong parity bit -> parity_err pulses and valid stays 0.

Source files
------------

// File: rtl/uart_receiver.sv
// uart_receiver: receive half of the on-chip UART feeding the memory-mapped I/O load path.
// Deserialises 8N1 frames (LSB first) from an asynchronous RX line and holds one byte
// behind a valid/ready handshake. Define UART_RX_PARITY_EN to receive 8E1 frames with
// parity checking; without it the parity state is absent and parity_err is tied low.
module uart_receiver #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  output logic       framing_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
  localparam int CW               = $clog2(SYMBOL_EDGE_TIME);
  localparam logic [CW-1:0] SYMBOL_LAST = CW'(SYMBOL_EDGE_TIME - 1);
  localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_TIME - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } state_t;

  state_t        state, state_nxt;
  logic          sync_meta, rx_s;
  logic [CW-1:0] clk_cnt, clk_cnt_nxt;
  logic [3:0]    bit_cnt, bit_cnt_nxt;
  logic [7:0]    shift_reg, shift_nxt;
  logic          deliver;
  logic          frame_bad;
`ifdef UART_RX_PARITY_EN
  logic          par_bad, par_bad_nxt;
  logic          par_fail;
`endif

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_meta <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      sync_meta <= serial_in;
      rx_s      <= sync_meta;
    end
  end

  // Frame state, counters and shift register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad   <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      clk_cnt   <= clk_cnt_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shift_reg <= shift_nxt;
`ifdef UART_RX_PARITY_EN
      par_bad   <= par_bad_nxt;
`endif
    end
  end

  // Next-state logic: mid-bit sampling driven by the clock counter's terminal counts.
  always_comb begin
    state_nxt   = state;
    clk_cnt_nxt = clk_cnt;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift_reg;
    deliver     = 1'b0;
    frame_bad   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_nxt = par_bad;
    par_fail    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt   = START;
          clk_cnt_nxt = '0;
`ifdef UART_RX_PARITY_EN
          par_bad_nxt = 1'b0;
`endif
        end
      end
      START: begin
        if (clk_cnt == SAMPLE_LAST) begin
          clk_cnt_nxt = '0;
          bit_cnt_nxt = '0;
          state_nxt   = rx_s ? IDLE : DATA;
        end else begin
          clk_cnt_nxt = clk_cnt + 1'b1;
        end
      end
      DATA: begin
        if (clk_cnt == SYMBOL_LAST) begin
          clk_cnt_nxt = '0;
          shift_nxt   = {rx_s, shift_reg[7:1]};
          bit_cnt_nxt = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end else begin
          clk_cnt_nxt = clk_cnt + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (clk_cnt == SYMBOL_LAST) begin
          clk_cnt_nxt = '0;
          state_nxt   = STOP;
          if (^{shift_reg, rx_s}) begin
            par_fail    = 1'b1;
            par_bad_nxt = 1'b1;
          end
        end else begin
          clk_cnt_nxt = clk_cnt + 1'b1;
        end
      end
`endif
      STOP: begin
        if (clk_cnt == SYMBOL_LAST) begin
          clk_cnt_nxt = '0;
          if (rx_s) begin
`ifdef UART_RX_PARITY_EN
            deliver = !par_bad;
`else
            deliver = 1'b1;
`endif
            state_nxt = IDLE;
          end else begin
            frame_bad = 1'b1;
            state_nxt = WAIT_HIGH;
          end
        end else begin
          clk_cnt_nxt = clk_cnt + 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Holding register with valid/ready handshake and registered one-cycle error pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out       <= 8'h00;
      data_out_valid <= 1'b0;
      framing_err    <= 1'b0;
      overrun        <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err     <= 1'b0;
`endif
    end else begin
      framing_err <= frame_bad;
      overrun     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err  <= par_fail;
`endif
      if (deliver) begin
        if (!data_out_valid || data_out_ready) begin
          data_out       <= shift_reg;
          data_out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_out_valid && data_out_ready) begin
        data_out_valid <= 1'b0;
      end
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed bench for uart_receiver at 10 clocks per bit.
// Honours UART_RX_PARITY_EN so the same vectors cover the 8E1 build.
module tb_uart_receiver;

  logic       clk;
  logic       rst;
  logic       serial_in;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready;
  logic       framing_err;
  logic       overrun;
  logic       parity_err;

  int checks;
  int errors;

  int  fe_cnt, ov_cnt, pe_cnt, rise_cnt, xfer_cnt;
  logic [7:0] xfer_data [0:31];
  logic prev_valid;
  time start_time, rise_time;

`ifdef UART_RX_PARITY_EN
  localparam int EXP_LAT = 108;
`else
  localparam int EXP_LAT = 98;
`endif

  uart_receiver #(
    .CLOCK_FREQ(1000),
    .BAUD_RATE (100)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .serial_in     (serial_in),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready),
    .framing_err   (framing_err),
    .overrun       (overrun),
    .parity_err    (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event monitor sampled on the falling edge, away from the active edge.
  initial begin
    fe_cnt = 0; ov_cnt = 0; pe_cnt = 0; rise_cnt = 0; xfer_cnt = 0;
    prev_valid = 1'b0;
    rise_time = 0;
  end
  always @(negedge clk) begin
    if (framing_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if (parity_err) pe_cnt++;
    if (data_out_valid && !prev_valid) begin
      rise_cnt++;
      rise_time = $time;
    end
    if (data_out_valid && data_out_ready && xfer_cnt < 32) begin
      xfer_data[xfer_cnt] = data_out;
      xfer_cnt++;
    end
    prev_valid = data_out_valid;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Sends one frame starting at the current falling edge; extra_low holds the line low after the stop bit.
  task automatic applyStimulus(input logic [7:0] b, input logic stop_bit, input logic bad_par, input int extra_low);
    serial_in  = 1'b0;
    start_time = $time;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      repeat (10) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    serial_in = (^b) ^ bad_par;
    repeat (10) @(negedge clk);
`else
    if (bad_par) $display("[TB] note: parity flip has no effect in the 8N1 build");
`endif
    serial_in = stop_bit;
    repeat (10) @(negedge clk);
    if (extra_low > 0) begin
      serial_in = 1'b0;
      repeat (extra_low) @(negedge clk);
    end
    serial_in = 1'b1;
  endtask

  task automatic pulseReady();
    data_out_ready = 1'b1;
    @(negedge clk);
    data_out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int fe0, ov0, rise0, xf0, pe0, lat;
    checks = 0;
    errors = 0;
    rst = 1'b0;
    serial_in = 1'b1;
    data_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_data", data_out, 8'h00);
    checkOutput("rst_valid", data_out_valid, 1'b0);
    checkOutput("rst_ferr", framing_err, 1'b0);
    checkOutput("rst_ovr", overrun, 1'b0);
    checkOutput("rst_perr", parity_err, 1'b0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // 1: single byte, latency and one-cycle consume
    ov0 = ov_cnt;
    applyStimulus(8'hA5, 1'b1, 1'b0, 0);
    repeat (3) @(negedge clk);
    lat = int'((rise_time - start_time) / 10);
    $display("[TB] t1 latency %0d clocks", lat);
    checkOutput("t1_latency_in_window", (lat >= EXP_LAT - 1 && lat <= EXP_LAT + 1), 1'b1);
    checkOutput("t1_data", data_out, 8'hA5);
    checkOutput("t1_valid", data_out_valid, 1'b1);
    pulseReady();
    checkOutput("t1_valid_after_ready", data_out_valid, 1'b0);
    checkOutput("t1_no_overrun", ov_cnt - ov0, 0);
    repeat (5) @(negedge clk);

    // 2: back-to-back bytes with the consumer stalled
    ov0 = ov_cnt;
    applyStimulus(8'h3C, 1'b1, 1'b0, 0);
    applyStimulus(8'hC3, 1'b1, 1'b0, 0);
    repeat (5) @(negedge clk);
    checkOutput("t2_data_kept", data_out, 8'h3C);
    checkOutput("t2_valid", data_out_valid, 1'b1);
    checkOutput("t2_overrun_once", ov_cnt - ov0, 1);
    pulseReady();
    repeat (5) @(negedge clk);

    // 3: consumer always ready
    data_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    ov0 = ov_cnt;
    xf0 = xfer_cnt;
    applyStimulus(8'h01, 1'b1, 1'b0, 0);
    applyStimulus(8'hFF, 1'b1, 1'b0, 0);
    applyStimulus(8'h80, 1'b1, 1'b0, 0);
    repeat (5) @(negedge clk);
    checkOutput("t3_transfers", xfer_cnt - xf0, 3);
    checkOutput("t3_byte0", xfer_data[xf0], 8'h01);
    checkOutput("t3_byte1", xfer_data[xf0 + 1], 8'hFF);
    checkOutput("t3_byte2", xfer_data[xf0 + 2], 8'h80);
    checkOutput("t3_no_overrun", ov_cnt - ov0, 0);
    data_out_ready = 1'b0;
    repeat (5) @(negedge clk);

    // 4: short glitch is rejected, then a clean frame
    fe0 = framing_err ? fe_cnt : fe_cnt;
    rise0 = rise_cnt;
    serial_in = 1'b0;
    repeat (3) @(negedge clk);
    serial_in = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("t4_glitch_valid", data_out_valid, 1'b0);
    checkOutput("t4_glitch_rise", rise_cnt - rise0, 0);
    checkOutput("t4_glitch_ferr", fe_cnt - fe0, 0);
    applyStimulus(8'h55, 1'b1, 1'b0, 0);
    repeat (3) @(negedge clk);
    checkOutput("t4_data", data_out, 8'h55);
    pulseReady();
    repeat (5) @(negedge clk);

    // 5: framing error followed by a long break
    fe0 = fe_cnt;
    rise0 = rise_cnt;
    applyStimulus(8'h12, 1'b0, 1'b0, 30);
    repeat (20) @(negedge clk);
    checkOutput("t5_ferr_once", fe_cnt - fe0, 1);
    checkOutput("t5_no_rise", rise_cnt - rise0, 0);
    checkOutput("t5_valid", data_out_valid, 1'b0);
    applyStimulus(8'h34, 1'b1, 1'b0, 0);
    repeat (3) @(negedge clk);
    checkOutput("t5_data", data_out, 8'h34);

    // 6: reset mid-frame while a byte is still held
    fe0 = fe_cnt;
    serial_in = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      serial_in = (8'h7E >> i) & 8'h01;
      repeat (10) @(negedge clk);
    end
    serial_in = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("t6_rst_data", data_out, 8'h00);
    checkOutput("t6_rst_valid", data_out_valid, 1'b0);
    checkOutput("t6_rst_ferr", framing_err, 1'b0);
    checkOutput("t6_rst_ovr", overrun, 1'b0);
    checkOutput("t6_rst_perr", parity_err, 1'b0);
    @(negedge clk);
    serial_in = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    applyStimulus(8'h7E, 1'b1, 1'b0, 0);
    repeat (3) @(negedge clk);
    checkOutput("t6_data", data_out, 8'h7E);
    checkOutput("t6_valid", data_out_valid, 1'b1);
    checkOutput("t6_no_ferr", fe_cnt - fe0, 0);

`ifdef UART_RX_PARITY_EN
    pulseReady();
    repeat (5) @(negedge clk);
    pe0 = pe_cnt;
    ov0 = ov_cnt;
    applyStimulus(8'h7E, 1'b1, 1'b1, 0);
    repeat (5) @(negedge clk);
    checkOutput("t6_parity_err", pe_cnt - pe0, 1);
    checkOutput("t6_parity_valid", data_out_valid, 1'b0);
    checkOutput("t6_parity_no_ovr", ov_cnt - ov0, 0);
`else
    pe0 = pe_cnt;
    checkOutput("t6_parity_tied_low", pe0, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
